// File: rtl/gpio_strap_scan_pkg.sv
// Shared definitions for the GPIO strap scanner: FSM state encoding and the
// default pad count, which the pad control register block also uses.
package gpio_strap_scan_pkg;

  localparam int GPIO_N_DEFAULT = 13;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEL  = 3'd1,
    ST_PU   = 3'd2,
    ST_PD   = 3'd3,
    ST_DONE = 3'd4
  } scan_state_t;

endpackage

// File: rtl/gpio_strap_settle_ctr.sv
// Settle-time down-counter. The counter is loaded with the settle count when
// a pull phase is entered. It then counts down to zero and holds there.
// 'expired' marks the cycle in which the pad input is sampled.
module gpio_strap_settle_ctr
  import gpio_strap_scan_pkg::*;
#(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_value,
  output logic                expired
);

  logic [SETTLE_W-1:0] count;

  // Load on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gpio_strap_scan.sv
// GPIO strap scanner. It walks the masked pins one at a time. Each pin gets a
// pull-up phase and then a pull-down phase, and the pad is sampled at the end
// of each phase. A 0 read under the pull-up marks the pin strapped low. A 1
// read under the pull-down marks it strapped high. Pins that are not under
// test keep the software pull settings.
// Optional build macro GPIO_STRAP_SCAN_AUTO_EN: when defined, one scan of all
// pins runs automatically after each reset, with settle count AUTO_SETTLE.
module gpio_strap_scan
  import gpio_strap_scan_pkg::*;
#(
  parameter int                  N_GPIO      = GPIO_N_DEFAULT,
  parameter int                  SETTLE_W    = 8,
  parameter logic [SETTLE_W-1:0] AUTO_SETTLE = 8'd63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_GPIO-1:0]   pin_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [N_GPIO-1:0]   gpio_in,
  input  logic [N_GPIO-1:0]   sw_pu,
  input  logic [N_GPIO-1:0]   sw_pd,
  output logic [N_GPIO-1:0]   gpio_pu,
  output logic [N_GPIO-1:0]   gpio_pd,
  output logic                busy,
  output logic                done,
  output logic [N_GPIO-1:0]   strap_hi,
  output logic [N_GPIO-1:0]   strap_lo
);

  localparam int IDX_W = (N_GPIO > 1) ? $clog2(N_GPIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_GPIO - 1);

  scan_state_t         state;
  scan_state_t         state_d;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_d;
  logic [N_GPIO-1:0]   mask_q;
  logic [SETTLE_W-1:0] settle_q;
  logic                ctr_load;
  logic                expired;
  logic                auto_start;
  logic                scan_go;
  logic [N_GPIO-1:0]   pu_d;
  logic [N_GPIO-1:0]   pd_d;

`ifdef GPIO_STRAP_SCAN_AUTO_EN
  logic auto_pending;

  // Arm one automatic scan per reset and drop it once IDLE has seen it.
  always_ff @(posedge clk) begin
    if (rst) begin
      auto_pending <= 1'b1;
    end else if (state == ST_IDLE) begin
      auto_pending <= 1'b0;
    end
  end

  assign auto_start = auto_pending && (state == ST_IDLE);
`else
  assign auto_start = 1'b0;
`endif

  assign scan_go = start || auto_start;

  // A single settle counter is shared by the pull-up and pull-down phases.
  gpio_strap_settle_ctr #(
    .SETTLE_W(SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .load_value (settle_q),
    .expired    (expired)
  );

  // Next-state and next-index decode. The counter is reloaded on every entry into PU or PD.
  always_comb begin
    state_d  = state;
    idx_d    = idx;
    ctr_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_go) begin
          state_d = ST_SEL;
          idx_d   = '0;
        end
      end
      ST_SEL: begin
        if (mask_q[idx]) begin
          state_d  = ST_PU;
          ctr_load = 1'b1;
        end else if (idx == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      ST_PU: begin
        if (expired) begin
          state_d  = ST_PD;
          ctr_load = 1'b1;
        end
      end
      ST_PD: begin
        if (expired) begin
          if (idx == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SEL;
            idx_d   = idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pull values for the coming cycle. The software settings apply everywhere except the pin in test.
  always_comb begin
    pu_d = sw_pu;
    pd_d = sw_pd;
    if (state_d == ST_PU) begin
      pu_d[idx_d] = 1'b1;
      pd_d[idx_d] = 1'b0;
    end else if (state_d == ST_PD) begin
      pu_d[idx_d] = 1'b0;
      pd_d[idx_d] = 1'b1;
    end
  end

  // FSM registers, scan capture, result sampling and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      mask_q   <= '0;
      settle_q <= '0;
      strap_hi <= '0;
      strap_lo <= '0;
      gpio_pu  <= '0;
      gpio_pd  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      gpio_pu <= pu_d;
      gpio_pd <= pd_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (scan_go) begin
            mask_q   <= auto_start ? {N_GPIO{1'b1}} : pin_mask;
            settle_q <= auto_start ? AUTO_SETTLE : settle_cycles;
            strap_hi <= '0;
            strap_lo <= '0;
          end
        end
        ST_PU: begin
          if (expired && !gpio_in[idx]) begin
            strap_lo[idx] <= 1'b1;
          end
        end
        ST_PD: begin
          if (expired && gpio_in[idx]) begin
            strap_hi[idx] <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/gpio_strap_scan.md
# gpio_strap_scan

Board strap detector for the GPIO pads. After a software or boot request, it walks the GPIOs one at a time, tries a pull-up and then a pull-down on each pin, and samples the pad input after each. From the two samples it classifies each pin as externally pulled high, externally pulled low, or floating. It sits between the pad control register block and the GPIO pads, and overrides the software `gpio_pu`/`gpio_pd` values only for the pin under test.

## Interface

Parameters:
- `N_GPIO`, default 13: number of GPIO pads scanned.
- `SETTLE_W`, default 8: width of the settle-time count.
- `AUTO_SETTLE`, default 8'd63: settle count used by the auto-scan (see Configuration).

Ports (`name direction width meaning`):
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: scan request; acted on only in IDLE.
- `pin_mask` in N_GPIO: pins to scan; captured at start.
- `settle_cycles` in SETTLE_W: settle count S; captured at start.
- `gpio_in` in N_GPIO: pad input values, already synchronised upstream.
- `sw_pu` in N_GPIO: software pull-up settings from the pad control registers.
- `sw_pd` in N_GPIO: software pull-down settings from the pad control registers.
- `gpio_pu` out N_GPIO: pull-up controls to the pads; registered.
- `gpio_pd` out N_GPIO: pull-down controls to the pads; registered.
- `busy` out 1: high whenever state != IDLE.
- `done` out 1: one-cycle pulse when the scan completes.
- `strap_hi` out N_GPIO: pin read 1 while pulled down, so it is externally driven high.
- `strap_lo` out N_GPIO: pin read 0 while pulled up, so it is externally driven low.

## Operation

- States are IDLE, SEL, PU, PD and DONE. A pin index `i` runs from 0 to N_GPIO-1.
- IDLE:
  - If `start` is high: capture `pin_mask` and S, clear `strap_hi` and `strap_lo`, set i=0, and go to SEL.
- SEL, which lasts 1 cycle:
  - If the captured mask bit i is set, go to PU.
  - Otherwise, if i is the last pin, go to DONE.
  - Otherwise, increment i and stay in SEL.
- PU, which lasts S+1 cycles:
  - Drive gpio_pu[i]=1 and gpio_pd[i]=0.
  - On the last cycle, sample gpio_in[i]; a sampled 0 sets strap_lo[i]. Then go to PD.
- PD, which lasts S+1 cycles:
  - Drive gpio_pu[i]=0 and gpio_pd[i]=1.
  - On the last cycle, sample gpio_in[i]; a sampled 1 sets strap_hi[i].
  - Then go to DONE if i is the last pin, otherwise increment i and go to SEL.
- DONE, which lasts 1 cycle: `done`=1, then go to IDLE.
- Classification: a floating pin ends with both bits 0. A pin ending with both bits 1 indicates contention or oscillation; both bits are kept and reported as-is.
- Pull outputs:
  - Pins not under test, and all pins outside PU/PD, take `sw_pu`/`sw_pd`.
  - The output flops are loaded from the next-state decode, so the pad sees exactly the state's value, with no glitches and no extra cycle of lag.
- S=0 is legal and gives a 1-cycle phase. The settle counter loads S on phase entry and samples when it reaches 0.

## Timing

Reset values:
- `gpio_pu` and `gpio_pd` are 0, and follow `sw_*` from the first cycle after reset.
- `busy`, `done`, `strap_hi` and `strap_lo` are 0.
- State is IDLE and i is 0.

Latency:
- With `start` high at cycle 0, `busy` is high from cycle 1.
- `done` is high at cycle 1 + N_GPIO + 2(S+1)·k, where k is the number of masked pins.
- `busy` falls in the cycle after `done`.

Boundary conditions:
- `start` while busy is ignored; it is not queued.
- `start` together with `rst`: `rst` wins.
- `rst` mid-scan: all state and outputs return to their reset values in the next cycle, and the override is released.
- Changes to `pin_mask` or `settle_cycles` during a scan are ignored.
- An all-zero mask completes with both result vectors at 0.
- `strap_hi`/`strap_lo` are held until the next accepted start, and are valid from the `done` cycle.

## Configuration

- `GPIO_STRAP_SCAN_AUTO_EN` defined:
  - The first cycle after `rst` deasserts acts as an internal start, with mask = all ones and S = `AUTO_SETTLE`.
  - This happens once per reset. The external `start` works as normal afterwards.
- Not defined: scans start only on `start`, and the `AUTO_SETTLE` parameter is unused.

## Structure

- Shared package/header holds:
  - the state encoding (IDLE, SEL, PU, PD, DONE);
  - the default `N_GPIO` value shared with the pad control register block.
- Sub-module `gpio_strap_settle_ctr`:
  - SETTLE_W down-counter with a load input and an `expired` output.
  - Instantiated once and reused for the PU and PD phases.
- The top level contains the FSM, the index counter, the result registers and the pull output mux/flops.

## Test plan

- **Single-pin scan:** N_GPIO=13, mask=13'h0001, S=3, pin 0 tied high externally, `start` at cycle 0 → gpio_pu[0]=1 on cycles 2–5, gpio_pd[0]=1 on cycles 6–9, done at cycle 22, strap_hi=13'h0001, strap_lo=0.
- **Classification:** mask=13'h0007; pin0 tied low, pin1 floating (follows the pull), pin2 tied high; S=0 → done at cycle 20, strap_lo=13'h0001, strap_hi=13'h0004.
- **Empty mask:** mask=0, sw_pu=13'h1FFF → done at cycle 14, gpio_pu=13'h1FFF throughout, results 0.
- **Restart and reset:** start while busy → no effect, done count unchanged. rst asserted at cycle 7 of the first test → next cycle busy=0, gpio_pu=gpio_pd=0, results 0, then gpio_pu/gpio_pd follow sw_* again.
- **Override isolation:** sw_pd=13'h1FFF during a scan of pin 3 → only bit 3 deviates, taking pu=1,pd=0 in PU and pu=0,pd=1 in PD.
- **Auto-scan (with `GPIO_STRAP_SCAN_AUTO_EN`):** after rst release, with no start, busy rises → done at 1 + 13 + 2·64·13 = 1678 cycles.
